gme_lookup_arb: RTL

Round-robin arbiter that shares one key-lookup engine between two gme match stages. It buffers the 512-bit keys from each stage, issues them one per cycle to the lookup engine, and records the issuing stage in an in-order tag FIFO. Returned 16-bit indices are steered back to the stage that issued the matching key. It sits between the gme stages' key/index ports and the lookup engine.

---
 rtl/gme_lookup_arb_if.sv | 44 ++++
 rtl/gme_lookup_arb.sv | 138 +++++++++++++
 2 files changed

// File: rtl/gme_lookup_arb_if.sv
// Key/index bus between the two gme match stages, the lookup arbiter and the lookup engine.
// The arbiter connects through the slave modport.
interface gme_lookup_arb_if #(
   parameter int unsigned KEY_W = 512,
   parameter int unsigned IDX_W = 16
);
   logic             in_arb_key0_wr;
   logic             in_arb_key1_wr;
   logic [KEY_W-1:0] in_arb_key0;
   logic [KEY_W-1:0] in_arb_key1;
   logic             out_arb_key0_alf;
   logic             out_arb_key1_alf;
   logic             out_arb_index0_wr;
   logic             out_arb_index1_wr;
   logic [IDX_W-1:0] out_arb_index0;
   logic [IDX_W-1:0] out_arb_index1;
   logic             in_arb_index0_alf;
   logic             in_arb_index1_alf;
   logic             out_arb_key_wr;
   logic [KEY_W-1:0] out_arb_key;
   logic             in_arb_key_alf;
   logic             in_arb_index_wr;
   logic [IDX_W-1:0] in_arb_index;
   logic             out_arb_index_alf;
   logic [31:0]      out_arb_status;

   modport slave (
      input  in_arb_key0_wr, in_arb_key1_wr, in_arb_key0, in_arb_key1,
      input  in_arb_index0_alf, in_arb_index1_alf, in_arb_key_alf,
      input  in_arb_index_wr, in_arb_index,
      output out_arb_key0_alf, out_arb_key1_alf,
      output out_arb_index0_wr, out_arb_index1_wr, out_arb_index0, out_arb_index1,
      output out_arb_key_wr, out_arb_key, out_arb_index_alf, out_arb_status
   );

   modport master (
      output in_arb_key0_wr, in_arb_key1_wr, in_arb_key0, in_arb_key1,
      output in_arb_index0_alf, in_arb_index1_alf, in_arb_key_alf,
      output in_arb_index_wr, in_arb_index,
      input  out_arb_key0_alf, out_arb_key1_alf,
      input  out_arb_index0_wr, out_arb_index1_wr, out_arb_index0, out_arb_index1,
      input  out_arb_key_wr, out_arb_key, out_arb_index_alf, out_arb_status
   );
endinterface

// File: rtl/gme_lookup_arb.sv
// Round-robin sharing of one key-lookup engine between two gme match stages; an in-order
// tag FIFO steers returned indices back to the stage that issued each key.
module gme_lookup_arb #(
   parameter int unsigned KEY_DEPTH  = 16,
   parameter int unsigned TAG_DEPTH  = 64,
   parameter int unsigned ALF_MARGIN = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   gme_lookup_arb_if.slave    bus
);
   localparam int unsigned KEY_W     = 512;
   localparam int unsigned IDX_W     = 16;
   localparam int unsigned KAW       = $clog2(KEY_DEPTH);
   localparam int unsigned KCW       = KAW + 1;
   localparam int unsigned TAW       = $clog2(TAG_DEPTH);
   localparam int unsigned TCW       = TAW + 1;
   localparam int unsigned ALF_LEVEL = KEY_DEPTH - ALF_MARGIN;

   logic [KEY_W-1:0]           key_mem [2][KEY_DEPTH];
   logic [1:0][KAW-1:0]        key_wr_ptr;
   logic [1:0][KAW-1:0]        key_rd_ptr;
   logic [1:0][KCW-1:0]        key_cnt;
   logic [1:0]                 key_alf;
   logic [1:0][7:0]            drop_cnt;
   logic                       last_grant;

   logic                       tag_mem [TAG_DEPTH];
   logic [TAW-1:0]             tag_wr_ptr;
   logic [TAW-1:0]             tag_rd_ptr;
   logic [TCW-1:0]             tag_cnt;
   logic [7:0]                 orphan_cnt;

   logic                       key_wr_q;
   logic [KEY_W-1:0]           key_q;
   logic [1:0]                 idx_wr_q;
   logic [1:0][IDX_W-1:0]      idx_q;

   logic [1:0][KEY_W-1:0]      key_in;
   logic [1:0]                 key_wr;
   logic [1:0]                 nonempty;
   logic [1:0]                 pop;
   logic [1:0]                 accept;
   logic [1:0]                 drop;
   logic [1:0][KCW-1:0]        key_cnt_nxt;
   logic                       grant;
   logic                       grant_id;
   logic                       tag_pop;
   logic                       tag_head;
   logic                       orphan;
   logic [KEY_W-1:0]           key_head;

   // Grant selection, FIFO push/pop qualification and next counts.
   always_comb begin
      key_in[0] = bus.in_arb_key0;
      key_in[1] = bus.in_arb_key1;
      key_wr[0] = bus.in_arb_key0_wr;
      key_wr[1] = bus.in_arb_key1_wr;
      tag_pop   = bus.in_arb_index_wr && (tag_cnt != '0);
      orphan    = bus.in_arb_index_wr && (tag_cnt == '0);
      for (int i = 0; i < 2; i++) nonempty[i] = (key_cnt[i] != '0);
      grant_id  = (&nonempty) ? ~last_grant : nonempty[1];
      // A tag popped this cycle frees its slot for a grant in the same cycle.
      grant     = !bus.in_arb_key_alf && |nonempty &&
                  ((tag_cnt - TCW'(tag_pop)) < TCW'(TAG_DEPTH));
      for (int i = 0; i < 2; i++) begin
         pop[i]         = grant && (grant_id == 1'(i));
         accept[i]      = key_wr[i] && ((key_cnt[i] != KCW'(KEY_DEPTH)) || pop[i]);
         drop[i]        = key_wr[i] && !accept[i];
         key_cnt_nxt[i] = key_cnt[i] + KCW'(accept[i]) - KCW'(pop[i]);
      end
      key_head = key_mem[grant_id][key_rd_ptr[grant_id]];
      tag_head = tag_mem[tag_rd_ptr];
   end

   // Storage arrays carry no reset; validity lives in the pointers and counts.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (accept[i]) key_mem[i][key_wr_ptr[i]] <= key_in[i];
      end
      if (grant) tag_mem[tag_wr_ptr] <= grant_id;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key_wr_ptr <= '0;
         key_rd_ptr <= '0;
         key_cnt    <= '0;
         key_alf    <= '0;
         drop_cnt   <= '0;
         last_grant <= 1'b1;
         tag_wr_ptr <= '0;
         tag_rd_ptr <= '0;
         tag_cnt    <= '0;
         orphan_cnt <= '0;
         key_wr_q   <= 1'b0;
         key_q      <= '0;
         idx_wr_q   <= '0;
         idx_q      <= '0;
      end else begin
         for (int i = 0; i < 2; i++) begin
            if (accept[i]) key_wr_ptr[i] <= key_wr_ptr[i] + KAW'(1);
            if (pop[i])    key_rd_ptr[i] <= key_rd_ptr[i] + KAW'(1);
            key_cnt[i] <= key_cnt_nxt[i];
            key_alf[i] <= (key_cnt_nxt[i] >= KCW'(ALF_LEVEL));
            if (drop[i] && (drop_cnt[i] != 8'hFF)) drop_cnt[i] <= drop_cnt[i] + 8'd1;
         end

         key_wr_q <= grant;
         if (grant) begin
            key_q      <= key_head;
            last_grant <= grant_id;
            tag_wr_ptr <= tag_wr_ptr + TAW'(1);
         end

         idx_wr_q <= '0;
         if (tag_pop) begin
            tag_rd_ptr         <= tag_rd_ptr + TAW'(1);
            idx_wr_q[tag_head] <= 1'b1;
            idx_q[tag_head]    <= bus.in_arb_index;
         end
         tag_cnt <= tag_cnt + TCW'(grant) - TCW'(tag_pop);

         if (orphan && (orphan_cnt != 8'hFF)) orphan_cnt <= orphan_cnt + 8'd1;
      end
   end

   assign bus.out_arb_key_wr    = key_wr_q;
   assign bus.out_arb_key       = key_q;
   assign bus.out_arb_index0_wr = idx_wr_q[0];
   assign bus.out_arb_index1_wr = idx_wr_q[1];
   assign bus.out_arb_index0    = idx_q[0];
   assign bus.out_arb_index1    = idx_q[1];
   assign bus.out_arb_key0_alf  = key_alf[0];
   assign bus.out_arb_key1_alf  = key_alf[1];
   assign bus.out_arb_index_alf = bus.in_arb_index0_alf | bus.in_arb_index1_alf;
   assign bus.out_arb_status    = {drop_cnt[0], drop_cnt[1], orphan_cnt, 8'(tag_cnt)};
endmodule
